// File: rtl/i2c_cfg_seq_if.sv
// Handshake bundle between the configuration sequencer and the I2C write controller.
interface i2c_cfg_seq_if;
    logic        strobe;
    logic        i2c_enable;
    logic [6:0]  i2c_slave_address;
    logic [15:0] i2c_register_address;
    logic        i2c_register_done;

    modport master (
        output strobe,
        output i2c_enable,
        output i2c_slave_address,
        output i2c_register_address,
        input  i2c_register_done
    );

    modport slave (
        input  strobe,
        input  i2c_enable,
        input  i2c_slave_address,
        input  i2c_register_address,
        output i2c_register_done
    );
endinterface

// File: rtl/i2c_cfg_seq.sv
// Walks a codec command ROM (writes, delays, end), drives the I2C controller with
// one enable per write, retries silently abandoned transfers and reports done/error.
module i2c_cfg_seq #(
    parameter int unsigned CLK_HZ        = 25_000_000,
    parameter int unsigned STROBE_HZ     = 100_000,
    parameter logic [6:0]  SLAVE_ADDR    = 7'h1A,
    parameter int unsigned ADDR_W        = 6,
    parameter int unsigned PWRUP_MS      = 10,
    parameter int unsigned TIMEOUT_TICKS = 255,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              start,
    i2c_cfg_seq_if.master     i2c,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [17:0]       rom_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_index
);

    localparam int unsigned DIV         = CLK_HZ / STROBE_HZ;
    localparam int unsigned DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned MS_TICKS    = STROBE_HZ / 1000;
    localparam int unsigned PWRUP_TICKS = PWRUP_MS * MS_TICKS;
    localparam int unsigned TICK_MAX0   = (PWRUP_TICKS > TIMEOUT_TICKS) ? PWRUP_TICKS : TIMEOUT_TICKS;
    localparam int unsigned TICK_MAX    = (TICK_MAX0 > MS_TICKS) ? TICK_MAX0 : MS_TICKS;
    localparam int unsigned TICK_W      = $clog2(TICK_MAX + 1);
    localparam int unsigned RETRY_W     = $clog2(MAX_RETRY + 2);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE,
        S_WAIT, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                strobe_q, strobe_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [15:0]         ms_q, ms_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [15:0]         reg_addr_q, reg_addr_d;
    logic                enable_q, enable_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   err_index_q, err_index_d;
    logic                done_prev_q, done_prev_d;
    logic                done_edge;

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        ms_d        = ms_q;
        retry_d     = retry_q;
        rom_addr_d  = rom_addr_q;
        reg_addr_d  = reg_addr_q;
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;

        // Free-running bit-phase divider; strobe_q is high exactly when the count is DIV-1.
        div_cnt_d   = (div_cnt_q == DIV_W'(DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
        strobe_d    = (div_cnt_d == DIV_W'(DIV - 1));

        done_prev_d = i2c.i2c_register_done;
        done_edge   = i2c.i2c_register_done & ~done_prev_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                    rom_addr_d  = '0;
                    state_d     = S_FETCH;
                end
            end
            S_PWRUP: begin
                if (PWRUP_TICKS == 0) begin
                    state_d = S_FETCH;
                end else if (strobe_q) begin
                    if (tick_q == TICK_W'(PWRUP_TICKS - 1)) begin
                        tick_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (rom_data[17:16])
                    OP_WRITE: begin
                        reg_addr_d = rom_data[15:0];
                        retry_d    = '0;
                        state_d    = S_ISSUE;
                    end
                    OP_DELAY: begin
                        if (rom_data[15:0] == 16'd0) begin
                            state_d = S_NEXT;
                        end else begin
                            ms_d    = rom_data[15:0];
                            tick_d  = '0;
                            state_d = S_DELAY;
                        end
                    end
                    default: begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_ISSUE: begin
                tick_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion edge takes priority over a coincident timeout.
                if (done_edge) begin
                    state_d = S_NEXT;
                end else if (strobe_q) begin
                    if (tick_q == TICK_W'(TIMEOUT_TICKS - 1)) begin
                        if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = S_ISSUE;
                        end else begin
                            err_index_d = rom_addr_q;
                            error_d     = 1'b1;
                            state_d     = S_ERROR;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            S_DELAY: begin
                if (strobe_q) begin
                    if (tick_q == TICK_W'(MS_TICKS - 1)) begin
                        tick_d = '0;
                        if (ms_q == 16'd1) begin
                            state_d = S_NEXT;
                        end else begin
                            ms_d = ms_q - 16'd1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            S_NEXT: begin
                if (rom_addr_q == {ADDR_W{1'b1}}) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        enable_d = (state_d == S_ISSUE);
        busy_d   = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_PWRUP;
            div_cnt_q   <= '0;
            strobe_q    <= 1'b0;
            tick_q      <= '0;
            ms_q        <= '0;
            retry_q     <= '0;
            rom_addr_q  <= '0;
            reg_addr_q  <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            strobe_q    <= strobe_d;
            tick_q      <= tick_d;
            ms_q        <= ms_d;
            retry_q     <= retry_d;
            rom_addr_q  <= rom_addr_d;
            reg_addr_q  <= reg_addr_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            done_prev_q <= done_prev_d;
        end
    end

    assign i2c.strobe               = strobe_q;
    assign i2c.i2c_enable           = enable_q;
    assign i2c.i2c_slave_address    = SLAVE_ADDR;
    assign i2c.i2c_register_address = reg_addr_q;
    assign rom_addr                 = rom_addr_q;
    assign busy                     = busy_q;
    assign done                     = done_q;
    assign error                    = error_q;
    assign err_index                = err_index_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Directed bench for i2c_cfg_seq: registered ROM model plus an I2C controller model
// that can abandon (NACK) chosen payloads.
module tb_i2c_cfg_seq;

    localparam int unsigned CLK_HZ        = 1_000_000;
    localparam int unsigned STROBE_HZ     = 100_000;
    localparam int unsigned ADDR_W        = 3;
    localparam int unsigned PWRUP_MS      = 2;
    localparam int unsigned TIMEOUT_TICKS = 20;
    localparam int unsigned MAX_RETRY     = 3;
    localparam int          PWRUP_CYC     = 2000;
    localparam int          ACK_LAT       = 30;

    logic              clk = 1'b0;
    logic              areset_n;
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [17:0]       rom_data;
    logic              busy, done, error;
    logic [ADDR_W-1:0] err_index;

    i2c_cfg_seq_if intf ();

    i2c_cfg_seq #(
        .CLK_HZ(CLK_HZ), .STROBE_HZ(STROBE_HZ), .SLAVE_ADDR(7'h1A), .ADDR_W(ADDR_W),
        .PWRUP_MS(PWRUP_MS), .TIMEOUT_TICKS(TIMEOUT_TICKS), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .areset_n(areset_n), .start(start), .i2c(intf),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
        .error(error), .err_index(err_index)
    );

    always #5 clk = ~clk;

    // Registered ROM
    logic [17:0] rom [8];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Controller model: clears done on enable, sets it ACK_LAT clks later unless NACKed
    logic [15:0] nack_pay;
    int          nack_upto;
    int          nack_hits = 0;
    int          lat;
    logic        pend;
    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            intf.i2c_register_done <= 1'b0;
            pend <= 1'b0;
            lat  <= 0;
        end else if (intf.i2c_enable) begin
            intf.i2c_register_done <= 1'b0;
            lat <= ACK_LAT;
            if (intf.i2c_register_address == nack_pay && nack_hits < nack_upto) begin
                pend      <= 1'b0;
                nack_hits <= nack_hits + 1;
            end else begin
                pend <= 1'b1;
            end
        end else if (pend) begin
            if (lat == 0) begin
                intf.i2c_register_done <= 1'b1;
                pend <= 1'b0;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    int cyc;
    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    // Enable/strobe monitor
    int          scnt = 0;
    int          en_cnt = 0;
    int          en_scnt [64];
    int          en_cyc  [64];
    logic [15:0] en_pay  [64];
    always @(negedge clk) begin
        if (intf.strobe) scnt++;
        if (intf.i2c_enable) begin
            if (en_cnt < 64) begin
                en_scnt[en_cnt] = scnt;
                en_cyc[en_cnt]  = cyc;
                en_pay[en_cnt]  = intf.i2c_register_address;
            end
            en_cnt++;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int k = 0;
        while (!(done || error) && k < budget) begin
            tick(1);
            k++;
        end
        chk({tag, "_end_reached"}, 32'(done | error), 32'd1);
    endtask

    task automatic wait_en(input string tag, input int target, input int budget);
        int k = 0;
        while (en_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        chk({tag, "_enable_seen"}, 32'(en_cnt >= target), 32'd1);
    endtask

    task automatic load_rom(input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2);
        for (int i = 0; i < 8; i++) rom[i] = 18'h30000;
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_strobe"},    32'(intf.strobe), 32'd0);
        chk({tag, "_enable"},    32'(intf.i2c_enable), 32'd0);
        chk({tag, "_regaddr"},   32'(intf.i2c_register_address), 32'd0);
        chk({tag, "_slave"},     32'(intf.i2c_slave_address), 32'h1A);
        chk({tag, "_rom_addr"},  32'(rom_addr), 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_done"},      32'(done), 32'd0);
        chk({tag, "_error"},     32'(error), 32'd0);
        chk({tag, "_err_index"}, 32'(err_index), 32'd0);
    endtask

    int base, s, s0;

    initial begin
        areset_n  = 1'b0;
        start     = 1'b0;
        nack_pay  = 16'hFFFF;
        nack_upto = 0;
        load_rom(18'h01E00, 18'h00F1F, 18'h30000);

        // Reset values and power-up run
        tick(3);
        chk_reset_outputs("rst");
        areset_n = 1'b1;
        tick(1);
        chk("pwrup_busy", 32'(busy), 32'd1);
        base = en_cnt;
        wait_end("run1", 6000);
        chk("run1_enables", 32'(en_cnt - base), 32'd2);
        chk("run1_pay0", 32'(en_pay[base]), 32'h1E00);
        chk("run1_pay1", 32'(en_pay[base + 1]), 32'h0F1F);
        chk_rng("run1_pwrup_delay", en_cyc[base], PWRUP_CYC, PWRUP_CYC + 4);
        chk("run1_done", 32'(done), 32'd1);
        chk("run1_busy", 32'(busy), 32'd0);
        chk("run1_error", 32'(error), 32'd0);
        chk("run1_rom_addr", 32'(rom_addr), 32'd2);

        // Restart after done, with an ignored start while busy
        base = en_cnt;
        s = cyc;
        pulse_start();
        chk("rerun_done_clr", 32'(done), 32'd0);
        chk("rerun_busy", 32'(busy), 32'd1);
        chk("rerun_rom_addr", 32'(rom_addr), 32'd0);
        wait_en("rerun", base + 2, 1000);
        pulse_start();
        wait_end("rerun", 2000);
        chk("rerun_enables", 32'(en_cnt - base), 32'd2);
        chk_rng("rerun_latency", en_cyc[base] - s, 2, 4);
        chk("rerun_rom_addr_end", 32'(rom_addr), 32'd2);
        chk("rerun_done", 32'(done), 32'd1);

        // DELAY 3 ms then a write
        load_rom(18'h10003, 18'h03400, 18'h30000);
        base = en_cnt;
        s  = cyc;
        s0 = scnt;
        pulse_start();
        wait_end("delay", 6000);
        chk("delay_enables", 32'(en_cnt - base), 32'd1);
        chk("delay_pay", 32'(en_pay[base]), 32'h3400);
        chk_rng("delay_strobes", en_scnt[base] - s0, 300, 301);
        chk_rng("delay_clks", en_cyc[base] - s, 2995, 3008);

        // One NACK on entry 1, then ACK
        load_rom(18'h01E00, 18'h00F1F, 18'h30000);
        nack_pay  = 16'h0F1F;
        nack_upto = nack_hits + 1;
        base = en_cnt;
        pulse_start();
        wait_end("nack1", 4000);
        chk("nack1_enables", 32'(en_cnt - base), 32'd3);
        chk("nack1_pay1", 32'(en_pay[base + 1]), 32'h0F1F);
        chk("nack1_pay2", 32'(en_pay[base + 2]), 32'h0F1F);
        chk("nack1_spacing", 32'(en_scnt[base + 2] - en_scnt[base + 1]), 32'(TIMEOUT_TICKS));
        chk("nack1_done", 32'(done), 32'd1);
        chk("nack1_error", 32'(error), 32'd0);

        // Entry 1 always NACKed: 4 attempts, then error
        nack_upto = nack_hits + 100;
        base = en_cnt;
        pulse_start();
        wait_end("nackall", 8000);
        chk("nackall_enables", 32'(en_cnt - base), 32'd5);
        for (int i = 1; i <= 4; i++)
            chk("nackall_pay", 32'(en_pay[base + i]), 32'h0F1F);
        for (int i = 2; i <= 4; i++)
            chk("nackall_spacing", 32'(en_scnt[base + i] - en_scnt[base + i - 1]), 32'(TIMEOUT_TICKS));
        chk("nackall_error", 32'(error), 32'd1);
        chk("nackall_err_index", 32'(err_index), 32'd1);
        chk("nackall_done", 32'(done), 32'd0);
        chk("nackall_busy", 32'(busy), 32'd0);

        // Implicit end at the last ROM index, all zero-length delays
        nack_upto = nack_hits;
        for (int i = 0; i < 8; i++) rom[i] = 18'h10000;
        base = en_cnt;
        pulse_start();
        chk("impl_error_clr", 32'(error), 32'd0);
        chk("impl_err_index_clr", 32'(err_index), 32'd0);
        wait_end("impl", 500);
        chk("impl_done", 32'(done), 32'd1);
        chk("impl_rom_addr", 32'(rom_addr), 32'd7);
        chk("impl_enables", 32'(en_cnt - base), 32'd0);

        // Reset asserted during WAIT
        load_rom(18'h01E00, 18'h00F1F, 18'h30000);
        base = en_cnt;
        pulse_start();
        wait_en("midrst", base + 1, 200);
        tick(5);
        areset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick(2);
        areset_n = 1'b1;
        base = en_cnt;
        wait_end("midrst_rerun", 6000);
        chk("midrst_enables", 32'(en_cnt - base), 32'd2);
        chk("midrst_pay0", 32'(en_pay[base]), 32'h1E00);
        chk_rng("midrst_pwrup_delay", en_cyc[base], PWRUP_CYC, PWRUP_CYC + 4);
        chk("midrst_done", 32'(done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
